// File: rtl/sm83_adr_gen_if.sv
// Purpose : bus bundle for sm83_adr_gen (CPU latch/step path + burst stream handshake).
// Latency : n/a (wiring only).
// Backpr. : burst_valid/burst_ready; the producer holds beats while burst_ready is low.
// Ports   : master = CPU/consumer side (drives controls, ready); slave = address generator.
interface sm83_adr_gen_if #(
  parameter int ADR_WIDTH = 16,
  parameter int CHANNELS  = 2,
  parameter int CNT_WIDTH = 8
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // CPU path
  logic [ADR_WIDTH-1:0] ain;
  logic [CH_W-1:0]      cpu_ch;
  logic                 ctl_al_hi_we;
  logic                 ctl_al_lo_we;
  logic                 ctl_inc_oe;
  logic                 ctl_inc_dec;
  logic                 ctl_inc_cy;
  logic                 ctl_page;
  logic [ADR_WIDTH-1:0] aout;
  logic [ADR_WIDTH-1:0] aout_inc;

  // burst sequencer
  logic                 burst_start;
  logic [CH_W-1:0]      burst_ch;
  logic [CNT_WIDTH-1:0] burst_len;
  logic                 burst_dec;
  logic                 burst_page;
  logic                 burst_valid;
  logic                 burst_ready;
  logic [ADR_WIDTH-1:0] burst_adr;
  logic                 burst_last;
  logic                 burst_busy;
  logic                 burst_done;

  modport master (
    output ain, cpu_ch, ctl_al_hi_we, ctl_al_lo_we, ctl_inc_oe, ctl_inc_dec, ctl_inc_cy, ctl_page,
    output burst_start, burst_ch, burst_len, burst_dec, burst_page, burst_ready,
    input  aout, aout_inc, burst_valid, burst_adr, burst_last, burst_busy, burst_done
  );

  modport slave (
    input  ain, cpu_ch, ctl_al_hi_we, ctl_al_lo_we, ctl_inc_oe, ctl_inc_dec, ctl_inc_cy, ctl_page,
    input  burst_start, burst_ch, burst_len, burst_dec, burst_page, burst_ready,
    output aout, aout_inc, burst_valid, burst_adr, burst_last, burst_busy, burst_done
  );
endinterface

// File: rtl/sm83_adr_gen.sv
// Purpose : multi-channel address latch with shared inc/dec and a burst address sequencer.
// Latency : state updates on the falling clk edge; first burst beat valid one cycle after start.
// Backpr. : a beat is held (address, count, outputs) until burst_ready is sampled high.
// Ports   : clk, reset (async, active-low), bus (sm83_adr_gen_if.slave: CPU path + burst stream).
module sm83_adr_gen #(
  parameter int ADR_WIDTH  = 16,
  parameter int CHANNELS   = 2,
  parameter int CNT_WIDTH  = 8,
  parameter int PAGE_WIDTH = 8
) (
  input logic           clk,
  input logic           reset,
  sm83_adr_gen_if.slave bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int HW   = ADR_WIDTH / 2;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADR_WIDTH-1:0] r_adr [CHANNELS];
  logic [ADR_WIDTH-1:0] w_adr_nxt [CHANNELS];
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CH_W-1:0]      r_ch;
  logic                 r_dec;
  logic                 r_page;
  logic                 r_done;

  logic [ADR_WIDTH-1:0] w_aout;
  logic [ADR_WIDTH-1:0] w_aout_inc;
  logic [ADR_WIDTH-1:0] w_wdat;
  logic [ADR_WIDTH-1:0] w_badr;
  logic                 w_bch_ok;
  logic                 w_valid;
  logic                 w_busy;
  logic                 w_last;
  logic                 w_load;
  logic                 w_done_nxt;
  logic                 w_acc;

  // In page mode only the low PAGE_WIDTH bits take the stepped value;
  // the carry/borrow out of the page is discarded by keeping the old upper bits.
  function automatic logic [ADR_WIDTH-1:0] f_step(input logic [ADR_WIDTH-1:0] a,
                                                  input logic dec, input logic cy,
                                                  input logic page);
    logic [ADR_WIDTH-1:0] full;
    logic [ADR_WIDTH-1:0] mask;
    full = dec ? a - {{(ADR_WIDTH-1){1'b0}}, cy} : a + {{(ADR_WIDTH-1){1'b0}}, cy};
    for (int i = 0; i < ADR_WIDTH; i++) mask[i] = (i < PAGE_WIDTH);
    return page ? ((full & mask) | (a & ~mask)) : full;
  endfunction

  // Channel selects decoded by compare so out-of-range codes read 0 and write nothing.
  always_comb begin
    w_aout   = '0;
    w_badr   = '0;
    w_bch_ok = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.cpu_ch == CH_W'(i))   w_aout   = r_adr[i];
      if (r_ch == CH_W'(i))         w_badr   = r_adr[i];
      if (bus.burst_ch == CH_W'(i)) w_bch_ok = 1'b1;
    end
  end

  assign w_aout_inc = f_step(w_aout, bus.ctl_inc_dec, bus.ctl_inc_cy, bus.ctl_page);
  assign w_wdat     = bus.ctl_inc_oe ? w_aout_inc : bus.ain;

  // Burst FSM: next state and outputs
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_busy      = 1'b0;
    w_last      = 1'b0;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.burst_start && w_bch_ok) begin
          if (bus.burst_len != '0) begin
            w_load      = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        w_valid = 1'b1;
        w_busy  = 1'b1;
        w_last  = (r_cnt == CNT_WIDTH'(1));
        if (bus.burst_ready && w_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_acc = w_valid & bus.burst_ready;

  // Burst step first, then CPU half-writes override on a shared channel.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_adr_nxt[i] = r_adr[i];
      if (w_acc && (r_ch == CH_W'(i)))
        w_adr_nxt[i] = f_step(r_adr[i], r_dec, 1'b1, r_page);
      if (bus.cpu_ch == CH_W'(i)) begin
        if (bus.ctl_al_hi_we) w_adr_nxt[i][ADR_WIDTH-1:HW] = w_wdat[ADR_WIDTH-1:HW];
        if (bus.ctl_al_lo_we) w_adr_nxt[i][HW-1:0]         = w_wdat[HW-1:0];
      end
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_ch   <= '0;
      r_dec  <= 1'b0;
      r_page <= 1'b0;
      r_done <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) r_adr[i] <= '0;
    end else begin
      r_done <= w_done_nxt;
      if (w_load) begin
        r_ch   <= bus.burst_ch;
        r_cnt  <= bus.burst_len;
        r_dec  <= bus.burst_dec;
        r_page <= bus.burst_page;
      end else if (w_acc) begin
        r_cnt  <= r_cnt - CNT_WIDTH'(1);
      end
      for (int i = 0; i < CHANNELS; i++) r_adr[i] <= w_adr_nxt[i];
    end
  end

  assign bus.aout        = w_aout;
  assign bus.aout_inc    = w_aout_inc;
  assign bus.burst_valid = w_valid;
  assign bus.burst_adr   = w_badr;
  assign bus.burst_last  = w_last;
  assign bus.burst_busy  = w_busy;
  assign bus.burst_done  = r_done;
endmodule

// File: tb/tb_sm83_adr_gen.sv
// Purpose : self-checking bench for sm83_adr_gen (CPU path, bursts, conflicts, reset).
// Latency : inputs driven just after the falling edge, outputs sampled at the rising edge.
// Backpr. : burst_ready driven from fixed patterns or at random.
module tb_sm83_adr_gen;
  logic clk;
  logic reset;

  sm83_adr_gen_if #(.ADR_WIDTH(16), .CHANNELS(2), .CNT_WIDTH(8)) bus ();

  sm83_adr_gen #(.ADR_WIDTH(16), .CHANNELS(2), .CNT_WIDTH(8), .PAGE_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int m [2];            // reference copy of the channel registers
  int exp_adr_q [$];    // expected beat addresses
  bit exp_last_q [$];   // expected last flags
  int exp_done = 0;     // done pulses still expected

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // 16-bit address step; page mode keeps the high byte and wraps the low byte.
  function automatic int mstep(input int a, input bit dec, input int cy, input bit page);
    int d;
    d = dec ? -cy : cy;
    if (!page) return (a + d + 65536) % 65536;
    return (a / 256) * 256 + ((a % 256) + d + 256) % 256;
  endfunction

  // Monitor: consumes the scoreboard whenever a beat is handed over or done pulses.
  always @(posedge clk) begin
    if (bus.burst_valid && bus.burst_ready) begin
      if (exp_adr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: got adr %h with no beat expected", bus.burst_adr);
      end else begin
        chk("beat_adr", int'(bus.burst_adr), exp_adr_q.pop_front());
        chk("beat_last", int'(bus.burst_last), int'(exp_last_q.pop_front()));
      end
    end
    if (bus.burst_done) begin
      total++;
      if (exp_done == 0) begin
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        exp_done--;
      end
    end
  end

  task automatic cpu_op(input int ch, input bit hi, input bit lo, input bit oe, input bit dec,
                        input int cy, input bit page, input int ain);
    int inc;
    int nv;
    bus.cpu_ch       = 1'(ch);
    bus.ctl_al_hi_we = hi;
    bus.ctl_al_lo_we = lo;
    bus.ctl_inc_oe   = oe;
    bus.ctl_inc_dec  = dec;
    bus.ctl_inc_cy   = cy[0];
    bus.ctl_page     = page;
    bus.ain          = 16'(ain);
    #1;
    inc = mstep(m[ch], dec, cy, page);
    chk("aout_inc", int'(bus.aout_inc), inc);
    @(negedge clk); #1;
    bus.ctl_al_hi_we = 1'b0;
    bus.ctl_al_lo_we = 1'b0;
    nv = oe ? inc : ain;
    m[ch] = (hi ? (nv & 'hFF00) : (m[ch] & 'hFF00)) | (lo ? (nv & 'hFF) : (m[ch] & 'hFF));
    chk("aout", int'(bus.aout), m[ch]);
  endtask

  task automatic peek(input string nm, input int ch, input int exp);
    bus.cpu_ch = 1'(ch);
    #1;
    chk(nm, int'(bus.aout), exp);
  endtask

  // pat_len==0: random ready; otherwise ready follows pat bits, then stays high.
  task automatic run_burst(input int ch, input int len, input bit dec, input bit page,
                           input int pat_len, input logic [31:0] pat, input int exp_cyc);
    int  a;
    int  cyc;
    bit  ok;
    a = m[ch];
    for (int k = 0; k < len; k++) begin
      exp_adr_q.push_back(a);
      exp_last_q.push_back(k == len - 1);
      a = mstep(a, dec, 1, page);
    end
    exp_done++;
    bus.burst_start = 1'b1;
    bus.burst_ch    = 1'(ch);
    bus.burst_len   = 8'(len);
    bus.burst_dec   = dec;
    bus.burst_page  = page;
    bus.burst_ready = 1'b0;
    @(negedge clk); #1;
    bus.burst_start = 1'b0;
    cyc = 0;
    ok  = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (!bus.burst_busy) begin ok = 1'b1; break; end
      if (pat_len == 0)        bus.burst_ready = ($urandom_range(0, 3) != 0);
      else if (cyc < pat_len)  bus.burst_ready = pat[cyc];
      else                     bus.burst_ready = 1'b1;
      cyc++;
      @(negedge clk); #1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL burst_timeout: got busy=1 after 400 cycles expected burst end");
    end
    bus.burst_ready = 1'b0;
    @(negedge clk); #1;
    if (exp_cyc >= 0) chk("burst_cycles", cyc, exp_cyc);
    chk("done_seen", exp_done, 0);
    m[ch] = a;
  endtask

  initial begin
    bus.ain = '0; bus.cpu_ch = '0; bus.ctl_al_hi_we = 0; bus.ctl_al_lo_we = 0;
    bus.ctl_inc_oe = 0; bus.ctl_inc_dec = 0; bus.ctl_inc_cy = 0; bus.ctl_page = 0;
    bus.burst_start = 0; bus.burst_ch = '0; bus.burst_len = '0; bus.burst_dec = 0;
    bus.burst_page = 0; bus.burst_ready = 0;
    m[0] = 0; m[1] = 0;
    reset = 1'b0;
    #2;
    chk("rst_valid", int'(bus.burst_valid), 0);
    chk("rst_busy", int'(bus.burst_busy), 0);
    chk("rst_done", int'(bus.burst_done), 0);
    chk("rst_last", int'(bus.burst_last), 0);
    peek("rst_aout0", 0, 0);
    peek("rst_aout1", 1, 0);
    #5 reset = 1'b1;
    @(negedge clk); #1;

    // CPU path on ch0
    cpu_op(0, 1, 1, 0, 0, 0, 0, 'h12FF); chk("tp1_load", int'(bus.aout), 'h12FF);
    cpu_op(0, 1, 1, 1, 0, 1, 0, 0);      chk("tp1_inc", int'(bus.aout), 'h1300);
    cpu_op(0, 1, 1, 1, 1, 1, 0, 0);
    cpu_op(0, 1, 1, 1, 1, 1, 0, 0);      chk("tp1_dec2", int'(bus.aout), 'h12FE);
    cpu_op(0, 1, 1, 1, 0, 0, 0, 0);      chk("tp1_cy0", int'(bus.aout), 'h12FE);
    cpu_op(0, 1, 0, 0, 0, 0, 0, 'hAB00); chk("tp1_hi_only", int'(bus.aout), 'hABFE);

    // wrap cases on ch1
    cpu_op(1, 1, 1, 0, 0, 0, 0, 'hFFFF);
    cpu_op(1, 1, 1, 1, 0, 1, 0, 0);      chk("wrap_full", int'(bus.aout), 'h0000);
    cpu_op(1, 1, 1, 0, 0, 0, 0, 'hFFFF);
    cpu_op(1, 1, 1, 1, 0, 1, 1, 0);      chk("wrap_page_inc", int'(bus.aout), 'hFF00);
    cpu_op(1, 1, 1, 1, 1, 1, 1, 0);      chk("wrap_page_dec", int'(bus.aout), 'hFFFF);
    peek("ch0_untouched", 0, 'hABFE);

    // random CPU traffic
    for (int i = 0; i < 40; i++)
      cpu_op($urandom_range(0, 1), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 1), 1'($urandom), int'($urandom_range(0, 65535)));

    // simple burst, ready always high
    cpu_op(1, 1, 1, 0, 0, 0, 0, 'hC000);
    run_burst(1, 4, 0, 0, 1, 32'h1, 4);
    peek("tp3_final", 1, 'hC004);
    chk("tp3_busy", int'(bus.burst_busy), 0);

    // backpressure 1,0,0,1,1 and zero length
    cpu_op(0, 1, 1, 0, 0, 0, 0, 'h3000);
    run_burst(0, 3, 0, 0, 5, 32'b11001, 5);
    peek("tp4_final", 0, 'h3003);
    run_burst(1, 0, 0, 0, 1, 32'h1, 0);
    peek("tp4_len0", 1, 'hC004);

    // random bursts against the model
    for (int i = 0; i < 10; i++) begin
      int ch;
      ch = $urandom_range(0, 1);
      cpu_op(ch, 1, 1, 0, 0, 0, 0, int'($urandom_range(0, 65535)));
      run_burst(ch, $urandom_range(1, 6), 1'($urandom), 1'($urandom), 0, 32'h0, -1);
      peek("rnd_final", ch, m[ch]);
    end

    // CPU and burst collide on ch0; start during RUN must be ignored
    cpu_op(0, 1, 1, 0, 0, 0, 0, 'h20FF);
    cpu_op(1, 1, 1, 0, 0, 0, 0, 'h7777);
    exp_adr_q.push_back('h20FF); exp_last_q.push_back(1'b0);
    exp_adr_q.push_back('h2155); exp_last_q.push_back(1'b0);
    exp_adr_q.push_back('h2156); exp_last_q.push_back(1'b1);
    exp_done++;
    bus.burst_start = 1'b1; bus.burst_ch = 1'b0; bus.burst_len = 8'd3;
    bus.burst_dec = 1'b0; bus.burst_page = 1'b0; bus.burst_ready = 1'b1;
    @(negedge clk); #1;
    bus.burst_ch = 1'b1; bus.burst_len = 8'd5;
    bus.cpu_ch = 1'b0; bus.ctl_al_lo_we = 1'b1; bus.ctl_inc_oe = 1'b0; bus.ain = 16'h0055;
    @(negedge clk); #1;
    bus.ctl_al_lo_we = 1'b0; bus.burst_start = 1'b0;
    begin
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        if (!bus.burst_busy) begin ok = 1'b1; break; end
        @(negedge clk); #1;
      end
      chk("tp5_ended", int'(ok), 1);
    end
    bus.burst_ready = 1'b0;
    @(negedge clk); #1;
    chk("tp5_done_seen", exp_done, 0);
    peek("tp5_ch0", 0, 'h2157);
    peek("tp5_ch1", 1, 'h7777);
    m[0] = 'h2157; m[1] = 'h7777;

    // reset in the middle of a burst
    cpu_op(1, 1, 1, 0, 0, 0, 0, 'h4000);
    exp_adr_q.push_back('h4000); exp_last_q.push_back(1'b0);
    exp_adr_q.push_back('h4001); exp_last_q.push_back(1'b0);
    bus.burst_start = 1'b1; bus.burst_ch = 1'b1; bus.burst_len = 8'd4;
    bus.burst_dec = 1'b0; bus.burst_page = 1'b0; bus.burst_ready = 1'b1;
    @(negedge clk); #1;
    bus.burst_start = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("tp6_busy_pre", int'(bus.burst_busy), 1);
    reset = 1'b0;
    #1;
    chk("tp6_valid", int'(bus.burst_valid), 0);
    chk("tp6_busy", int'(bus.burst_busy), 0);
    chk("tp6_done", int'(bus.burst_done), 0);
    peek("tp6_ch1", 1, 0);
    peek("tp6_ch0", 0, 0);
    bus.burst_ready = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    reset = 1'b1;
    m[0] = 0; m[1] = 0;
    @(negedge clk); #1;
    run_burst(0, 2, 0, 0, 1, 32'h1, 2);
    peek("tp6_after", 0, 'h0002);

    chk("beats_left", exp_adr_q.size(), 0);
    chk("done_left", exp_done, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sm83_adr_gen.md
Name: sm83_adr_gen

Overview:
Multi-channel address latch with a shared incrementer/decrementer. Each channel can also be driven by an autonomous burst sequencer. It is the next generation of the CPU address-increment unit: the CPU keeps its per-half latch/increment path, and DMA-style or block-transfer engines can stream successive addresses from any channel via a valid/ready handshake. An optional page-wrap mode confines stepping to the low address bits, as used for high-page (0xFFxx) transfers.

Parameters:
ADR_WIDTH, 16, address width in bits; must be even (hi/lo halves of ADR_WIDTH/2).
CHANNELS, 2, number of address registers; at least 2; CH_W = $clog2(CHANNELS).
CNT_WIDTH, 8, burst length counter width.
PAGE_WIDTH, 8, number of low bits that step in page mode; must be between 1 and ADR_WIDTH.

Ports:
clk  in  1  clock; all state updates on the falling edge.
reset  in  1  asynchronous, active-low reset.
ain  in  ADR_WIDTH  CPU address bus input.
cpu_ch  in  CH_W  channel selected for the CPU path.
ctl_al_hi_we  in  1  write the high half of channel cpu_ch.
ctl_al_lo_we  in  1  write the low half of channel cpu_ch.
ctl_inc_oe  in  1  write source: 1 = stepped value, 0 = ain.
ctl_inc_dec  in  1  1 = decrement, 0 = increment.
ctl_inc_cy  in  1  step amount (0 or 1).
ctl_page  in  1  page mode for the CPU step.
aout  out  ADR_WIDTH  registered value of channel cpu_ch.
aout_inc  out  ADR_WIDTH  combinational stepped value of aout.
burst_start  in  1  request a burst; sampled only in IDLE.
burst_ch  in  CH_W  channel the burst uses.
burst_len  in  CNT_WIDTH  number of beats.
burst_dec  in  1  burst direction; 1 = decrement.
burst_page  in  1  burst page mode.
burst_valid  out  1  burst_adr is valid.
burst_ready  in  1  consumer accepts the beat.
burst_adr  out  ADR_WIDTH  current burst address (the burst channel's register).
burst_last  out  1  current beat is the final beat.
burst_busy  out  1  FSM is in RUN.
burst_done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - All channel registers, counter and latched burst fields clear to 0; FSM goes to IDLE.
  - burst_valid, burst_busy, burst_last and burst_done drop to 0 immediately.
  - Reset asserted mid-burst aborts the burst; no burst_done pulse is generated.
- Step function step(a, dec, cy, page):
  - Non-page: a + cy or a - cy, modulo 2^ADR_WIDTH (0xFFFF+1 = 0x0000; 0x0000-1 = 0xFFFF).
  - Page: the low PAGE_WIDTH bits step modulo 2^PAGE_WIDTH; the upper bits are held (0xFFFF+1 = 0xFF00).
- CPU path:
  - aout = reg[cpu_ch].
  - aout_inc = step(aout, ctl_inc_dec, ctl_inc_cy, ctl_page).
  - On a falling edge, each half whose we is set loads the matching half of (ctl_inc_oe ? aout_inc : ain).
  - The halves are independently writable.
  - If cpu_ch >= CHANNELS: writes are ignored and aout reads 0.
- Burst FSM, two states:
  - IDLE, burst_start with burst_len>0: latch ch/len/dec/page, load cnt=burst_len, go to RUN.
  - IDLE, burst_start with burst_len=0: no beats; burst_done pulses on the next edge.
  - IDLE, burst_ch >= CHANNELS: start ignored.
  - RUN: burst_valid=1, burst_adr = reg[latched ch], burst_last = (cnt==1), burst_busy=1.
  - RUN, on an edge with valid & ready: reg[ch] <- step(reg[ch], dec, 1, page) and cnt <- cnt-1.
  - RUN, accepted beat with cnt==1: go to IDLE and pulse burst_done for one cycle.
  - RUN without ready: all state and outputs hold.
  - burst_start while in RUN is ignored.
- Throughput and latency: one beat per cycle when ready is held high. The first valid appears the cycle after start is sampled.
- CPU and burst writing the same channel on the same edge:
  - The CPU write wins for the written half/halves.
  - An unwritten half takes the burst step result.
  - The beat still counts as accepted.
- The burst register update is visible on aout the cycle after the edge if cpu_ch matches.

Test Plan:
1. CPU path: ain=0x12FF, both we, oe=0 -> aout=0x12FF; then oe=1, cy=1, dec=0 -> 0x1300; dec=1, cy=1 twice -> 0x12FE; ctl_inc_cy=0 with oe=1 -> value unchanged.
2. Wrap: reg=0xFFFF, +1 non-page -> 0x0000; reg=0xFFFF, +1 page -> 0xFF00; reg=0xFF00, -1 page -> 0xFFFF.
3. Burst: ch1=0xC000, len=4, ready=1 -> burst_adr C000, C001, C002, C003 on consecutive cycles; last on C003; done pulse; ch1=0xC004; busy low afterwards.
4. Backpressure and zero length: len=3, ready toggles 1,0,0,1,1 -> addresses advance only on ready cycles and exactly 3 beats occur; len=0 -> done pulse with no valid.
5. Conflict: during a burst on ch0, CPU writes ch0 lo with ain=0x0055 on a beat edge -> lo=0x55, hi=stepped hi, cnt decremented; burst_start during RUN is ignored.
6. Reset mid-burst (cnt=2): reset low asynchronously -> valid/busy go to 0 at once, all registers 0, no done pulse; a new start after release works normally.
